// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  // Bit/byte sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  // SDA levels of the ninth (acknowledge) bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Bit counter covers the 8 data bits of a byte.
  localparam int BIT_CNT_W = 3;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

endpackage

// File: rtl/i2c_target_reader_if.sv
// Pad and register-bank signals of the I2C target reader.
// Latency: n/a (wiring only).
// Backpressure: none; the bank answers combinationally on data_in.
// Ports: scl_in/sda_in raw pads, sda_oe open-drain pull-down, addr/data_in
//        register bank read port, rd_strobe byte-latch pulse, busy transfer flag.
interface i2c_target_reader_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       rd_strobe;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, data_in,
    output sda_oe, addr, rd_strobe, busy
  );

  modport master (
    output scl_in, sda_in, data_in,
    input  sda_oe, addr, rd_strobe, busy
  );
endinterface

// File: rtl/i2c_line_filter.sv
// Pad line conditioner: 2-flop synchronizer, FILTER_LEN glitch filter, edge events.
// Latency: level and rise/fall pulse appear 2 + FILTER_LEN clk after a pad edge.
// Backpressure: none; events are single-clk pulses.
// Ports: clk/rst, line_raw (asynchronous pad), level (filtered), rise/fall (1-clk).
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with the
  // current level; the FILTER_LEN-th such sample flips the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= line_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_reader.sv
// I2C target that sets a register pointer on write and streams bank bytes on read.
// Latency: sda_oe moves 1 clk after a filtered SCL fall; addr follows the pointer by 1 clk.
// Backpressure: none; SCL is never stretched, the bank must answer combinationally.
// Ports: clk/rst, bus (slave modport: pads, bank read port, rd_strobe, busy).
module i2c_target_reader
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         NUM_REGS   = 4,
  parameter int         FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_target_reader_if.slave    bus
);

  localparam logic [3:0] PTR_LAST   = 4'(NUM_REGS - 1);
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk      (clk),
    .rst      (rst),
    .line_raw (bus.scl_in),
    .level    (scl_lvl),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk      (clk),
    .rst      (rst),
    .line_raw (bus.sda_in),
    .level    (sda_lvl),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_t               state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [3:0]           ptr, ptr_nxt;
  logic [3:0]           addr_q;
  logic                 rw, rw_nxt;
  logic                 sda_oe, sda_oe_nxt;
  logic                 rd_strobe, rd_strobe_nxt;
  logic                 busy, busy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      addr_q    <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      rd_strobe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      ptr       <= ptr_nxt;
      addr_q    <= ptr;
      rw        <= rw_nxt;
      sda_oe    <= sda_oe_nxt;
      rd_strobe <= rd_strobe_nxt;
      busy      <= busy_nxt;
    end
  end

  // sda_oe is always the complement of the SDA level we want on the bus.
  // In the ACK states bit_cnt is reused as a phase flag: 0 until the
  // acknowledge has been driven (ADDR_ACK/PTR_ACK) or sampled (TX_ACK).
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    sda_oe_nxt    = sda_oe;
    rd_strobe_nxt = 1'b0;
    busy_nxt      = busy;

    if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      unique case (state)
        IDLE, WAIT_STOP: ;

        ADDR, PTR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda_lvl};
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = (state == ADDR) ? ADDR_ACK : PTR_ACK;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == '0) begin
              if (shift[7:1] == DEV_ADDR) begin
                sda_oe_nxt  = ~ACK;
                rw_nxt      = shift[0];
                bit_cnt_nxt = 1;
              end else begin
                state_nxt = WAIT_STOP;
              end
            end else if (rw) begin
              // First read byte: latch the bank and present its MSB.
              shift_nxt     = bus.data_in;
              sda_oe_nxt    = ~bus.data_in[7];
              rd_strobe_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              state_nxt     = TX;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = PTR;
            end
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == '0) begin
              if (shift < NUM_REGS_B) begin
                ptr_nxt    = shift[3:0];
                sda_oe_nxt = ~ACK;
              end else begin
                sda_oe_nxt = ~NACK;
              end
              bit_cnt_nxt = 1;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = WAIT_STOP;
            end
          end
        end

        TX: begin
          // MSB is already on the bus from the load; each fall moves on one bit,
          // and the eighth fall hands SDA back for the controller's acknowledge.
          if (scl_fall) begin
            if (bit_cnt == BIT_LAST) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = TX_ACK;
            end else begin
              shift_nxt   = {shift[6:0], 1'b0};
              sda_oe_nxt  = ~shift[6];
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end
        end

        TX_ACK: begin
          if (scl_rise && bit_cnt == '0) begin
            if (sda_lvl == ACK) begin
              ptr_nxt     = (ptr == PTR_LAST) ? 4'd0 : ptr + 4'd1;
              bit_cnt_nxt = 1;
            end else begin
              state_nxt = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt != '0) begin
            // addr has followed the incremented pointer for many clks by now.
            shift_nxt     = bus.data_in;
            sda_oe_nxt    = ~bus.data_in[7];
            rd_strobe_nxt = 1'b1;
            bit_cnt_nxt   = '0;
            state_nxt     = TX;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe;
  assign bus.addr      = addr_q;
  assign bus.rd_strobe = rd_strobe;
  assign bus.busy      = busy;

endmodule

// File: doc/i2c_target_reader.md
# i2c_target_reader

I2C target (slave) front end that serves the peripheral holding registers to an external I2C controller. It decodes bus START/STOP and bytes on SCL/SDA, and holds a register pointer. It drives the register-bank address `addr` and consumes the byte returned on `data_in`, shifting it out MSB-first with auto-increment. It sits directly downstream of the holding-register bank and directly upstream of the board's open-drain SDA/SCL pads.

## Interface
- `DEV_ADDR`, 7'h42: 7-bit target address this block answers to.
- `NUM_REGS`, 4: number of valid register indices; pointer range is 0..NUM_REGS-1, with NUM_REGS ≤ 16.
- `FILTER_LEN`, 3: number of consecutive identical synchronized samples required to accept a new SCL/SDA level.

- `clk`  in  1  system clock; must be ≥ 20× SCL frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_in`  in  1  raw SCL pad input (asynchronous).
- `sda_in`  in  1  raw SDA pad input (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low, 0 = release (open drain).
- `addr`  out  4  register index to the holding-register bank; equals the current pointer.
- `data_in`  in  8  register contents for `addr` (combinational from the bank).
- `rd_strobe`  out  1  one-clk pulse when `data_in` is latched for transmission.
- `busy`  out  1  1 from an accepted START to the next STOP.

## Operation
- **Line filtering:** each line passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter. Filtered levels produce one-clk rise/fall events.
- **START and STOP:**
  - START (also repeated START): SDA fall while SCL high. Enter ADDR, clear bit counter, set `busy`=1.
  - STOP: SDA rise while SCL high. Enter IDLE from any state, `sda_oe`=0, `busy`=0. The pointer is kept.
- **Bit timing:** data is sampled on SCL rise. `sda_oe` changes only on SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, WAIT_STOP.
- **ADDR:** shift 8 bits, MSB first.
  - If bits[7:1] == DEV_ADDR: drive ACK in ADDR_ACK and record R/W = bit0.
  - On mismatch: WAIT_STOP, never drive SDA.
- **Write transfer (R/W=0):** after ADDR_ACK, go to PTR and receive 1 byte.
  - If byte < NUM_REGS: pointer ← byte[3:0] and ACK.
  - Otherwise: NACK (release SDA), pointer unchanged.
  - After PTR_ACK, go to WAIT_STOP. Further data bytes are NACKed by releasing SDA; they are never stored.
- **Read transfer (R/W=1):**
  - On the SCL fall that ends the ADDR_ACK clock: latch `data_in` into the shift register, pulse `rd_strobe`, enter TX.
  - In TX, drive `sda_oe` = ~shift[7], then shift left on each SCL fall, for 8 bits.
  - At the 8th SCL fall, release SDA and enter TX_ACK.
  - TX_ACK samples the controller's ACK on SCL rise:
    - ACK (0): pointer ← (pointer+1) wrapping NUM_REGS-1 → 0. On the following SCL fall, latch the new `data_in`, pulse `rd_strobe`, re-enter TX.
    - NACK (1): WAIT_STOP.
- **WAIT_STOP:** `sda_oe`=0. Leave only on STOP (→ IDLE) or START (→ ADDR).
- **START/STOP priority:** a START or STOP detected in any state overrides the bit machine in the same clk.
- **Reset values:** `sda_oe`=0, `addr`=0, pointer=0, `rd_strobe`=0, `busy`=0, state=IDLE, filtered lines=1.
- **Reset mid-transfer:** releases SDA immediately, because the reset is asynchronous.

## Timing
- Event detection latency from a pad edge: 2 (synchronizer) + FILTER_LEN clk.
- `sda_oe` updates 1 clk after a detected SCL fall. This guarantees SDA setup before the next SCL rise when clk ≥ 20× SCL.
- `addr` is registered. It changes 1 clk after the pointer update, and ≥ 2 clk before `data_in` is latched.
- `rd_strobe` is high for exactly 1 clk, coincident with the shift-register load.
- No clock stretching: SCL is never driven.

## Structure
- Shared package `i2c_pkg`:
  - state enum;
  - ACK/NACK constants (0/1);
  - bit-counter width (3 bits).
- Sub-module `i2c_line_filter`: synchronizer, glitch filter and rise/fall event outputs. Instantiated twice, once for SCL and once for SDA.
- Top level: bit/byte FSM, pointer register, shift register.

## Test plan
- Write pointer, then read 2 bytes:
  - Stimulus: START, 0x84 (write to 0x42), 0x01, STOP. Then START, 0x85, read 2 bytes with ACK then NACK, STOP.
  - Bank: adc1=0x5A, adc2=0xC3.
  - Required: both address bytes ACKed, pointer byte ACKed; bytes out 0x5A then 0xC3; `addr` 1 → 2; 2 `rd_strobe` pulses.
- Wrap-around: pointer=3, read 2 bytes with ACK → bytes from `addr` 3 then 0 (ID 0xAA); `addr` returns to 0.
- Address mismatch: START, 0x90 → SDA never driven through the whole transfer; `busy` stays 1 until STOP; pointer unchanged.
- Out-of-range pointer: write pointer 0x07 → NACK on 9th clock; a subsequent read returns the previous pointer's register.
- Robustness:
  - A 1-clk SDA glitch while SCL is high produces no START/STOP.
  - A repeated START mid-TX restarts address decode.
  - `rst` asserted mid-TX forces `sda_oe`=0 asynchronously and resets the pointer to 0.
